// File: rtl/camera_frame_writer.sv
// OV2640 capture writer: frames the byte bus on vsync/href, packs RGB565 pairs to RGB444 and
// streams sequential BRAM writes. Define CAM_DECIMATE_EN for 2:1 decimation in both axes.
module camera_frame_writer #(
  parameter int unsigned HActive = 640,
  parameter int unsigned VActive = 480,
  parameter int unsigned AddrW   = 19
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             vsync_i,
  input  logic             href_i,
  input  logic [7:0]       data_in_i,
  output logic             wr_en_o,
  output logic [AddrW-1:0] wr_addr_o,
  output logic [11:0]      wr_data_o,
  output logic             frame_done_o,
  output logic [7:0]       frame_cnt_o,
  output logic             line_err_o
);

`ifdef CAM_DECIMATE_EN
  localparam int unsigned Depth = (HActive / 2) * (VActive / 2);
`else
  localparam int unsigned Depth = HActive * VActive;
`endif

  // Pair counter saturates one past HActive so over-long lines still fail the line check.
  localparam int unsigned XW = $clog2(HActive + 2);
  localparam int unsigned YW = $clog2(VActive + 1);
  localparam logic [XW-1:0]    XLim     = XW'(HActive);
  localparam logic [XW-1:0]    XMax     = XW'(HActive + 1);
  localparam logic [YW-1:0]    YLim     = YW'(VActive);
  localparam logic [AddrW-1:0] AddrLast = AddrW'(Depth - 1);

  typedef enum logic [1:0] {StSyncHi, StSyncLo, StActive} state_e;

  state_e state_q, state_d;

  logic             phase_q, phase_d;
  logic [6:0]       hi_q, hi_d;
  logic             href_q, href_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic             wr_en_q, wr_en_d;
  logic [AddrW-1:0] wr_addr_q, wr_addr_d;
  logic [11:0]      wr_data_q, wr_data_d;
  logic             frame_done_q, frame_done_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             line_err_q, line_err_d;

  logic        in_range;
  logic        decim_ok;
  logic [11:0] pixel;

  assign in_range = (x_q < XLim) && (y_q < YLim);

`ifdef CAM_DECIMATE_EN
  assign decim_ok = ~x_q[0] & ~y_q[0];
`else
  assign decim_ok = 1'b1;
`endif

  // hi_q keeps {R[4:1], G[5:3]}; the low byte is taken straight off the bus.
  assign pixel = {hi_q[6:3], hi_q[2:0], data_in_i[7], data_in_i[4:1]};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StSyncHi;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSyncHi: if (vsync_i)  state_d = StSyncLo;
      StSyncLo: if (!vsync_i) state_d = StActive;
      StActive: if (vsync_i)  state_d = StSyncLo;
      default:                state_d = StSyncHi;
    endcase
  end

  always_comb begin
    phase_d      = phase_q;
    hi_d         = hi_q;
    href_d       = href_i;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    line_err_d   = line_err_q;

    if (state_q != StActive) begin
      phase_d = 1'b0;
      x_d     = '0;
      y_d     = '0;
      addr_d  = '0;
    end else if (vsync_i) begin
      // Frame end also aborts any pending half pixel.
      phase_d = 1'b0;
      x_d     = '0;
      if (y_q == YLim) begin
        frame_done_d = 1'b1;
        frame_cnt_d  = frame_cnt_q + 8'd1;
      end else begin
        line_err_d = 1'b1;
      end
    end else if (href_i) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        hi_d = {data_in_i[7:4], data_in_i[2:0]};
      end else begin
        x_d = (x_q == XMax) ? x_q : x_q + 1'b1;
        if (in_range && decim_ok) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = pixel;
          if (addr_q != AddrLast) begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
    end else begin
      phase_d = 1'b0;
      x_d     = '0;
      if (href_q) begin
        if ((x_q != XLim) || phase_q) begin
          line_err_d = 1'b1;
        end
        y_d = (y_q == YLim) ? y_q : y_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      phase_q      <= 1'b0;
      hi_q         <= '0;
      href_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      line_err_q   <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      href_q       <= href_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      line_err_q   <= line_err_d;
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign frame_done_o = frame_done_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign line_err_o   = line_err_q;

endmodule

// File: tb/tb_camera_frame_writer.sv
// Scoreboard bench for camera_frame_writer at 8x4 pixels; honours CAM_DECIMATE_EN when defined.
module tb_camera_frame_writer;
  localparam int unsigned H  = 8;
  localparam int unsigned V  = 4;
  localparam int unsigned AW = 5;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          vsync_i = 1'b0;
  logic          href_i = 1'b0;
  logic [7:0]    data_in_i = 8'h00;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [11:0]   wr_data_o;
  logic          frame_done_o;
  logic [7:0]    frame_cnt_o;
  logic          line_err_o;

  always #5 clk_i = ~clk_i;

  camera_frame_writer #(
    .HActive(H),
    .VActive(V),
    .AddrW  (AW)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .vsync_i     (vsync_i),
    .href_i      (href_i),
    .data_in_i   (data_in_i),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .frame_done_o(frame_done_o),
    .frame_cnt_o (frame_cnt_o),
    .line_err_o  (line_err_o)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [11:0]   data;
  } wr_t;

  wr_t      sb_q[$];
  int       total = 0;
  int       bad = 0;
  bit       cap = 1'b0;
  int       m_addr = 0;
  int       m_y = 0;
  int       m_wr = 0;
  int       wr_seen = 0;
  logic [7:0] m_cnt = 8'd0;
  bit       m_err = 1'b0;
  logic     prev_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit keep(input int x, input int y);
    if (x >= int'(H) || y >= int'(V)) return 1'b0;
`ifdef CAM_DECIMATE_EN
    return (x % 2 == 0) && (y % 2 == 0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Writes appear one clock after their low byte; the monitor pops them at the falling edge.
  always @(negedge clk_i) begin
    if (frame_done_o) check("done_width", prev_done, 0);
    prev_done = frame_done_o;
    if (wr_en_o) begin
      wr_seen++;
      check("wr_expected", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        wr_t e;
        e = sb_q.pop_front();
        check("wr_addr", wr_addr_o, e.addr);
        check("wr_data", wr_data_o, e.data);
      end
    end
  end

  task automatic pulse_vsync();
    bit fin;
    bit do_done;
    href_i = 1'b0;
    vsync_i = 1'b1;
    fin = cap;
    do_done = cap && (m_y == int'(V));
    if (do_done) m_cnt++;
    else if (cap) m_err = 1'b1;
    tick();
    check("frame_done", frame_done_o, do_done);
    check("frame_cnt", frame_cnt_o, m_cnt);
    check("line_err", line_err_o, m_err);
    if (fin) begin
      check("wr_count", wr_seen, m_wr);
      check("sb_empty", sb_q.size(), 0);
    end
    tick();
    check("done_low", frame_done_o, 0);
    tick();
    vsync_i = 1'b0;
    tick();
    tick();
    cap = 1'b1;
    m_addr = 0;
    m_y = 0;
    m_wr = 0;
    wr_seen = 0;
  endtask

  task automatic send_line(input int nbytes, input logic [7:0] hi, input logic [7:0] lo,
                           input logic [11:0] px, input int rst_at);
    for (int i = 0; i < nbytes; i++) begin
      href_i = 1'b1;
      data_in_i = (i % 2 == 0) ? hi : lo;
      if (i == rst_at) begin
        rst_ni = 1'b0;
        cap = 1'b0;
        m_cnt = 8'd0;
        m_err = 1'b0;
      end else if (cap && (i % 2 == 1) && keep(i / 2, m_y)) begin
        sb_q.push_back({AW'(m_addr), px});
        m_addr++;
        m_wr++;
      end
      tick();
      if (i == rst_at) begin
        rst_ni = 1'b1;
        check("mid_rst_wr_en", wr_en_o, 0);
        check("mid_rst_addr", wr_addr_o, 0);
        check("mid_rst_data", wr_data_o, 0);
        check("mid_rst_cnt", frame_cnt_o, 0);
        check("mid_rst_err", line_err_o, 0);
      end
    end
    href_i = 1'b0;
    if (cap) begin
      if (nbytes != 2 * int'(H)) m_err = 1'b1;
      m_y++;
    end
    tick();
    tick();
  endtask

  task automatic full_frame();
    for (int l = 0; l < int'(V); l++) send_line(2 * H, 8'hF8, 8'h1F, 12'hF0F, -1);
  endtask

  initial begin
    tick();
    tick();
    check("rst_wr_en", wr_en_o, 0);
    check("rst_addr", wr_addr_o, 0);
    check("rst_data", wr_data_o, 0);
    check("rst_done", frame_done_o, 0);
    check("rst_cnt", frame_cnt_o, 0);
    check("rst_err", line_err_o, 0);
    rst_ni = 1'b1;
    tick();

    // Bytes before the first vsync must be ignored.
    send_line(2 * H, 8'hF8, 8'h1F, 12'hF0F, -1);

    // Basic full frame.
    pulse_vsync();
    full_frame();
    pulse_vsync();

    // Colour conversion patterns.
    send_line(2 * H, 8'h07, 8'hE0, 12'h0F0, -1);
    send_line(2 * H, 8'h00, 8'h1E, 12'h00F, -1);
    send_line(2 * H, 8'hF8, 8'h1F, 12'hF0F, -1);
    send_line(2 * H, 8'hF8, 8'h1F, 12'hF0F, -1);
    pulse_vsync();

    // Short frame, then a full frame from address 0.
    send_line(2 * H, 8'hF8, 8'h1F, 12'hF0F, -1);
    send_line(2 * H, 8'hF8, 8'h1F, 12'hF0F, -1);
    pulse_vsync();
    full_frame();
    pulse_vsync();

    // Reset in line 3 with href still active.
    send_line(2 * H, 8'hF8, 8'h1F, 12'hF0F, -1);
    send_line(2 * H, 8'h07, 8'hE0, 12'h0F0, -1);
    send_line(2 * H, 8'hF8, 8'h1F, 12'hF0F, 6);
    send_line(2 * H, 8'hF8, 8'h1F, 12'hF0F, -1);
    pulse_vsync();
    full_frame();
    pulse_vsync();

    // Odd-length line 2; line_err sticks through the next good frame.
    send_line(2 * H, 8'hF8, 8'h1F, 12'hF0F, -1);
    send_line(2 * H, 8'hF8, 8'h1F, 12'hF0F, -1);
    send_line(2 * H - 1, 8'h07, 8'hE0, 12'h0F0, -1);
    send_line(2 * H, 8'hF8, 8'h1F, 12'hF0F, -1);
    pulse_vsync();
    full_frame();
    pulse_vsync();

    // Run frames until the counter wraps to zero.
    begin
      int n;
      n = 256 - int'(m_cnt);
      for (int f = 0; f < n; f++) begin
        full_frame();
        pulse_vsync();
      end
    end
    check("cnt_wrap", frame_cnt_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/camera_frame_writer.md
# camera_frame_writer

Capture-side frame writer between the OV2640 byte bus and port A of the frame-buffer BRAM. It runs on the camera pixel clock. It frames the byte stream on vsync/href and pairs bytes into RGB565 pixels, converting each to RGB444. It then emits sequential write strobes and addresses for a frame buffer of fixed size, optionally 2:1 decimated in both axes. It also reports frame completion, a frame count and malformed-line errors to the top level.

## Interface
- H_ACTIVE, 640: pixels per camera line (byte pairs per href pulse)
- V_ACTIVE, 480: lines per frame
- ADDR_W, 19: write-address width; must hold the last buffer address
- clk  in  1  pixel clock (pclk from the camera); all logic on rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-low
- vsync  in  1  camera vsync, high during vertical blanking
- href  in  1  camera href, high while line bytes are valid
- data_in  in  8  camera byte bus, sampled every clk while href high
- wr_en  out  1  buffer write strobe, one cycle per stored pixel
- wr_addr  out  ADDR_W  buffer write address
- wr_data  out  12  pixel {R[3:0],G[3:0],B[3:0]}
- frame_done  out  1  one-cycle pulse on completion of a full frame
- frame_cnt  out  8  completed-frame counter
- line_err  out  1  sticky malformed-line flag

## Operation
- States:
  - SYNC_HI: wait for vsync=1, then go to SYNC_LO.
  - SYNC_LO: wait for vsync=0, then go to ACTIVE with byte phase, pixel, line and address counters cleared.
  - ACTIVE: capture.
- After reset the block starts in SYNC_HI, so a partial frame is never written.
- Byte phase toggles on each href=1 cycle and clears on href=0.
  - Phase 0 byte: hi = {R5, G[5:3]}.
  - Phase 1 byte: lo = {G[2:0], B5}.
- Pixel conversion: R = hi[7:4], G = {hi[2:0], lo[7]}, B = lo[4:1].
- Pixel x counts 0..H_ACTIVE-1 within a line. Pixels with x ≥ H_ACTIVE are discarded.
- Line y increments on each href falling edge. Lines with y ≥ V_ACTIVE are discarded.
- Storage rule: pixel stored if x<H_ACTIVE and y<V_ACTIVE (decimation rules under Configuration).
- wr_addr is a running counter, not a multiply:
  - It is set to 0 on entering ACTIVE.
  - It increments after each write.
  - It never exceeds the buffer depth minus 1.
- Line check at each href falling edge in ACTIVE: if the byte-pair count ≠ H_ACTIVE, or byte phase = 1 (odd byte count), line_err is set.
- line_err is cleared only by reset.
- vsync rising in ACTIVE:
  - If y = V_ACTIVE: pulse frame_done and increment frame_cnt (255 wraps to 0).
  - If y < V_ACTIVE (short frame): no pulse, no count, line_err set.
  - In both cases go to SYNC_LO.
- vsync rising while href=1 aborts the line: no write for the pending half pixel, same handling as above.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_cnt=0, line_err=0, state SYNC_HI.
- Reset mid-frame: outputs are at reset values on the next edge. Capture resumes only after a full vsync high→low.
- Latency: wr_en, wr_addr and wr_data are registered and valid one clk after the phase-1 byte is sampled. They are stable for exactly one cycle.
- Writes are at most one every 2 clks; there is no backpressure and the BRAM accepts every strobe.
- frame_done asserts one clk after the vsync=1 sample.
- frame_cnt updates in the same cycle frame_done asserts.
- The last write of a frame (addr = depth-1) precedes frame_done.

## Configuration
- CAM_DECIMATE_EN defined:
  - A pixel is stored only if x is even and y is even.
  - Buffer depth is (H_ACTIVE/2)·(V_ACTIVE/2), i.e. 76800 at defaults.
  - wr_addr increments once per stored pixel.
- CAM_DECIMATE_EN undefined:
  - Every pixel with x<H_ACTIVE, y<V_ACTIVE is stored.
  - Buffer depth is H_ACTIVE·V_ACTIVE.
- The line_err check and frame_done behaviour are identical in both builds.

## Test plan
Bench parameters: H_ACTIVE=8, V_ACTIVE=4, ADDR_W=5, clock-gen pclk; decimation undefined unless stated.
1. Reset, then one vsync pulse, then 4 lines of 16 bytes (hi=0xF8, lo=0x1F) → 32 writes, addr 0..31, wr_data=0xF0F; frame_done pulses once after the next vsync rise; frame_cnt=1; line_err=0.
2. Bytes hi=0x07, lo=0xE0 → wr_data=0x0F0. Bytes hi=0x00, lo=0x1E → wr_data=0x00F.
3. Line 2 carries 15 bytes → line_err=1 and stays 1 through the next good frame. The short frame still ends with frame_done, since y=4.
4. vsync rises after 2 lines → no frame_done, frame_cnt unchanged, line_err=1. The next full frame restarts at addr 0.
5. rst=0 for one clk during line 3, then rst=1 with href still active → no writes until vsync high→low; next frame writes from addr 0.
6. CAM_DECIMATE_EN, same stimulus as test 1 → 8 writes, addr 0..7, only x,y even; frame_done once. Drive 256 frames → frame_cnt wraps to 0.
